// File: rtl/sna_response_packetizer.sv
// Slave-side NoC response adapter: serialises AXI4-Lite R/B responses into
// header/[body]/tail flit packets on a VC chosen once per packet.
module sna_response_packetizer #(
  parameter int FLIT_W    = 37,
  parameter int NUM_VC    = 8,
  parameter int R_BODY_EN = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rvalid,
  output logic              rready,
  input  logic [FLIT_W-1:0] r_header,
  input  logic [FLIT_W-1:0] r_body,
  input  logic [FLIT_W-1:0] r_tail,
  input  logic              bvalid,
  output logic              bready,
  input  logic [FLIT_W-1:0] b_header,
  input  logic [FLIT_W-1:0] b_tail,
  input  logic [NUM_VC-1:0] is_allocatable,
  input  logic [NUM_VC-1:0] is_on_off,
  output logic [FLIT_W-1:0] noc_data,
  output logic              is_valid,
  output logic [NUM_VC-1:0] vc_sel
);

  // state | meaning
  // IDLE  | waiting for an R or B response and a free VC
  // HEAD  | header flit pending on the chosen VC
  // BODY  | body (read data) flit pending, R packets only
  // TAIL  | tail flit pending; packet done once it is sent
  typedef enum logic [1:0] {IDLE, HEAD, BODY, TAIL} state_t;

  state_t            state_q, state_d;
  logic              prio_r_q, prio_r_d;
  logic              is_r_q, is_r_d;
  logic [FLIT_W-1:0] hdr_q, hdr_d, body_q, body_d, tail_q, tail_d;
  logic [FLIT_W-1:0] noc_data_q, noc_data_d, cur_flit;
  logic [NUM_VC-1:0] vc_q, vc_d, vc_sel_q, vc_sel_d, alloc_low;
  logic              is_valid_q, is_valid_d;
  logic              grant_r, grant_b, accept_ok, send;

  always_comb begin
    grant_r   = rvalid & (~bvalid | prio_r_q);
    grant_b   = bvalid & (~rvalid | ~prio_r_q);
    accept_ok = ~reset & (state_q == IDLE) & (|is_allocatable);
    rready    = accept_ok & grant_r;
    bready    = accept_ok & grant_b;
    // Two's-complement trick isolates the lowest set bit as a one-hot.
    alloc_low = is_allocatable & (~is_allocatable + NUM_VC'(1));
    send      = (state_q != IDLE) & (|(is_on_off & vc_q));
    case (state_q)
      HEAD:    cur_flit = hdr_q;
      BODY:    cur_flit = body_q;
      TAIL:    cur_flit = tail_q;
      default: cur_flit = hdr_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    prio_r_d   = prio_r_q;
    is_r_d     = is_r_q;
    hdr_d      = hdr_q;
    body_d     = body_q;
    tail_d     = tail_q;
    vc_d       = vc_q;
    noc_data_d = noc_data_q;
    is_valid_d = 1'b0;
    vc_sel_d   = vc_sel_q;
    case (state_q)
      IDLE: begin
        vc_sel_d = '0;
        if (rready || bready) begin
          state_d  = HEAD;
          is_r_d   = rready;
          prio_r_d = ~rready;
          vc_d     = alloc_low;
          hdr_d    = rready ? r_header : b_header;
          tail_d   = rready ? r_tail : b_tail;
          if (rready) body_d = r_body;
        end
      end
      default: begin
        if (send) begin
          is_valid_d = 1'b1;
          noc_data_d = cur_flit;
          vc_sel_d   = vc_q;
          case (state_q)
            HEAD:    state_d = (is_r_q && (R_BODY_EN != 0)) ? BODY : TAIL;
            BODY:    state_d = TAIL;
            default: state_d = IDLE;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      prio_r_q   <= 1'b1;
      is_r_q     <= 1'b0;
      hdr_q      <= '0;
      body_q     <= '0;
      tail_q     <= '0;
      vc_q       <= '0;
      noc_data_q <= '0;
      is_valid_q <= 1'b0;
      vc_sel_q   <= '0;
    end else begin
      state_q    <= state_d;
      prio_r_q   <= prio_r_d;
      is_r_q     <= is_r_d;
      hdr_q      <= hdr_d;
      body_q     <= body_d;
      tail_q     <= tail_d;
      vc_q       <= vc_d;
      noc_data_q <= noc_data_d;
      is_valid_q <= is_valid_d;
      vc_sel_q   <= vc_sel_d;
    end
  end

  assign noc_data = noc_data_q;
  assign is_valid = is_valid_q;
  assign vc_sel   = vc_sel_q;

endmodule
